wb_timer_sched: RTL

//  Multiplexes NUM_CH software deadline channels onto the single mtime/mtimecmp compare of wb_timer.

---
 rtl/wb_timer_sched.sv | 232 +++++++++++++++++++++++
 1 files changed

// File: rtl/wb_timer_sched.sv
// Multiplexes NUM_CH software deadline channels onto the single mtimecmp of wb_timer.
// Optional auto-reload channels are enabled by defining TIMER_SCHED_PERIODIC_EN.
module wb_timer_sched #(
   parameter int          WB_DATA_WIDTH = 32,
   parameter int          WB_ADDR_WIDTH = 32,
   parameter int          WB_SEL_WIDTH  = 4,
   parameter int          NUM_CH        = 4,
   parameter logic [31:0] TIMER_BASE    = 32'h0
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic [WB_ADDR_WIDTH-1:0] wb_addr_i,
   input  logic [WB_DATA_WIDTH-1:0] wb_data_i,
   input  logic                     wb_we_i,
   input  logic [WB_SEL_WIDTH-1:0]  wb_sel_i,
   input  logic                     wb_stb_i,
   input  logic                     wb_cyc_i,
   output logic                     wb_ack_o,
   output logic [WB_DATA_WIDTH-1:0] wb_data_o,
   output logic [WB_ADDR_WIDTH-1:0] m_addr_o,
   output logic [WB_DATA_WIDTH-1:0] m_data_o,
   output logic                     m_we_o,
   output logic [WB_SEL_WIDTH-1:0]  m_sel_o,
   output logic                     m_stb_o,
   output logic                     m_cyc_o,
   input  logic                     m_ack_i,
   input  logic [WB_DATA_WIDTH-1:0] m_data_i,
   input  logic                     timer_irq_i,
   output logic                     irq_o
);
   // wb_timer register offsets: mtime lo/hi, mtimecmp lo/hi
   localparam logic [31:0] OFF_MTIME_LO = 32'h0;
   localparam logic [31:0] OFF_MTIME_HI = 32'h4;
   localparam logic [31:0] OFF_CMP_LO   = 32'h8;
   localparam logic [31:0] OFF_CMP_HI   = 32'hC;

   typedef enum logic [3:0] {
      S_INIT_HI, S_INIT_LO, S_IDLE, S_RD_HI0, S_RD_LO, S_RD_HI1,
      S_EXPIRE, S_SCAN, S_PROG_HI0, S_PROG_LO, S_PROG_HI1
   } state_t;

   state_t            state;
   logic [NUM_CH-1:0] pending, armed, irq_en, exp_hit;
   logic [63:0]       deadline [NUM_CH];
`ifdef TIMER_SCHED_PERIODIC_EN
   logic [63:0]       period [NUM_CH];
`endif
   logic              resched;
   logic [1:0]        holdoff;
   logic [2:0]        idx;
   logic              last_ch;
   logic [31:0]       hi0, lo;
   logic [63:0]       mtime, min_dl;
   logic              bus_req, bus_we, bus_done;
   logic [31:0]       bus_off, bus_data;
   logic [5:0]        word;
   logic [2:0]        ch;
   logic              wr_en;
   logic [31:0]       rdata;
   logic              unused;

   assign word     = wb_addr_i[7:2];
   assign ch       = word[3:1];
   assign wr_en    = wb_cyc_i & wb_stb_i & wb_we_i & ~wb_ack_o;
   assign last_ch  = (idx == 3'(NUM_CH - 1));
   assign bus_done = m_cyc_o & m_ack_i;
   assign m_sel_o  = '1;
   assign irq_o    = |(pending & irq_en);
   assign wb_data_o = WB_DATA_WIDTH'(rdata);
   assign unused   = ^{wb_sel_i, wb_addr_i};

   always_comb begin
      exp_hit = '0;
      for (int i = 0; i < NUM_CH; i++)
         if (state == S_EXPIRE && idx == 3'(i) && armed[i] && deadline[i] <= mtime)
            exp_hit[i] = 1'b1;
   end

   always_comb begin
      rdata = '0;
      case (word)
         6'd0: rdata[NUM_CH-1:0] = pending;
         6'd1: rdata[NUM_CH-1:0] = armed;
         6'd2: rdata[NUM_CH-1:0] = irq_en;
         6'd3: rdata[0] = (state != S_IDLE);
         default: begin
            for (int i = 0; i < NUM_CH; i++) begin
               if (word[5:4] == 2'b01 && ch == 3'(i))
                  rdata = word[0] ? deadline[i][63:32] : deadline[i][31:0];
`ifdef TIMER_SCHED_PERIODIC_EN
               if (word[5:4] == 2'b10 && ch == 3'(i))
                  rdata = word[0] ? period[i][63:32] : period[i][31:0];
`endif
            end
         end
      endcase
   end

   // Master transaction issued by each bus-owning state
   always_comb begin
      bus_req  = 1'b1;
      bus_we   = 1'b1;
      bus_off  = OFF_CMP_HI;
      bus_data = 32'hFFFF_FFFF;
      case (state)
         S_INIT_HI, S_PROG_HI0: begin end
         S_INIT_LO:  bus_off = OFF_CMP_LO;
         S_RD_HI0, S_RD_HI1: begin bus_we = 1'b0; bus_off = OFF_MTIME_HI; bus_data = '0; end
         S_RD_LO:    begin bus_we = 1'b0; bus_off = OFF_MTIME_LO; bus_data = '0; end
         S_PROG_LO:  begin bus_off = OFF_CMP_LO; bus_data = min_dl[31:0]; end
         S_PROG_HI1: bus_data = min_dl[63:32];
         default:    bus_req = 1'b0;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state    <= S_INIT_HI;
         pending  <= '0;
         armed    <= '0;
         irq_en   <= '0;
         resched  <= 1'b0;
         holdoff  <= '0;
         idx      <= '0;
         hi0      <= '0;
         lo       <= '0;
         mtime    <= '0;
         min_dl   <= '0;
         wb_ack_o <= 1'b0;
         m_cyc_o  <= 1'b0;
         m_stb_o  <= 1'b0;
         m_we_o   <= 1'b0;
         m_addr_o <= '0;
         m_data_o <= '0;
         for (int i = 0; i < NUM_CH; i++) begin
            deadline[i] <= '0;
`ifdef TIMER_SCHED_PERIODIC_EN
            period[i]   <= '0;
`endif
         end
      end else begin
         wb_ack_o <= wb_cyc_i & wb_stb_i & ~wb_ack_o;
         if (bus_req) begin
            if (!m_cyc_o) begin
               m_cyc_o  <= 1'b1;
               m_stb_o  <= 1'b1;
               m_we_o   <= bus_we;
               m_addr_o <= WB_ADDR_WIDTH'(TIMER_BASE + bus_off);
               m_data_o <= WB_DATA_WIDTH'(bus_data);
            end else if (m_ack_i) begin
               m_cyc_o <= 1'b0;
               m_stb_o <= 1'b0;
               m_we_o  <= 1'b0;
            end
         end
         case (state)
            S_INIT_HI: if (bus_done) state <= S_INIT_LO;
            S_INIT_LO: if (bus_done) begin holdoff <= 2'd2; state <= S_IDLE; end
            S_IDLE: begin
               if (holdoff != 2'd0) holdoff <= holdoff - 2'd1;
               if (timer_irq_i && holdoff == 2'd0) state <= S_RD_HI0;
               else if (resched) begin
                  resched <= 1'b0;
                  idx     <= '0;
                  min_dl  <= '1;
                  state   <= S_SCAN;
               end
            end
            S_RD_HI0: if (bus_done) begin hi0 <= m_data_i[31:0]; state <= S_RD_LO; end
            S_RD_LO:  if (bus_done) begin lo <= m_data_i[31:0]; state <= S_RD_HI1; end
            S_RD_HI1: if (bus_done) begin
               // A carry between the LO and HI reads: re-read LO against the new HI
               if (m_data_i[31:0] != hi0) begin
                  hi0   <= m_data_i[31:0];
                  state <= S_RD_LO;
               end else begin
                  mtime <= {m_data_i[31:0], lo};
                  idx   <= '0;
                  state <= S_EXPIRE;
               end
            end
            S_EXPIRE: begin
               for (int i = 0; i < NUM_CH; i++) begin
                  if (exp_hit[i]) begin
`ifdef TIMER_SCHED_PERIODIC_EN
                     if (period[i] != 64'd0) deadline[i] <= deadline[i] + period[i];
                     else armed[i] <= 1'b0;
`else
                     armed[i] <= 1'b0;
`endif
                  end
               end
               pending <= pending | exp_hit;
               if (last_ch) begin idx <= '0; min_dl <= '1; state <= S_SCAN; end
               else idx <= idx + 3'd1;
            end
            S_SCAN: begin
               for (int i = 0; i < NUM_CH; i++)
                  if (idx == 3'(i) && armed[i] && deadline[i] < min_dl) min_dl <= deadline[i];
               if (last_ch) state <= S_PROG_HI0;
               else idx <= idx + 3'd1;
            end
            S_PROG_HI0: if (bus_done) state <= S_PROG_LO;
            S_PROG_LO:  if (bus_done) state <= S_PROG_HI1;
            S_PROG_HI1: if (bus_done) begin holdoff <= 2'd2; state <= S_IDLE; end
            default: state <= S_INIT_HI;
         endcase
         // Slave writes come last so software wins over the FSM, except that an expiry set beats W1C
         if (wr_en) begin
            case (word)
               6'd0: pending <= (pending & ~wb_data_i[NUM_CH-1:0]) | exp_hit;
               6'd2: irq_en  <= wb_data_i[NUM_CH-1:0];
               default: begin
                  for (int i = 0; i < NUM_CH; i++) begin
                     if (word[5:4] == 2'b01 && ch == 3'(i)) begin
                        if (word[0]) begin deadline[i][63:32] <= wb_data_i[31:0]; armed[i] <= 1'b1; end
                        else begin deadline[i][31:0] <= wb_data_i[31:0]; armed[i] <= 1'b0; end
                        resched <= 1'b1;
                     end
`ifdef TIMER_SCHED_PERIODIC_EN
                     if (word[5:4] == 2'b10 && ch == 3'(i)) begin
                        if (word[0]) period[i][63:32] <= wb_data_i[31:0];
                        else period[i][31:0] <= wb_data_i[31:0];
                     end
`endif
                  end
               end
            endcase
         end
      end
   end
endmodule
